// File: rtl/thread_lsu.sv
// thread_lsu -- per-thread load/store unit sitting behind the thread datapath.
//
// Takes one decoded LDR/STR request at a time (address in rs, store data in rt),
// runs it as a valid/ready transaction on the data-memory port, and holds the
// loaded value on lsu_out until the datapath acks it.
//
// Optional feature: define LSU_TIMEOUT_EN to abort a transaction that has sat
// in WAITING for TIMEOUT_CYCLES cycles without ready (sets error, a read returns
// all ones). Without the macro WAITING lasts indefinitely and error is tied to 0.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   enable, start         thread active / request pulse (accepted only in IDLE)
//   op_read, op_write     decoded op; read wins if both are set
//   rs, rt                address operand / store data, latched at accept
//   ack                   datapath consumed the result (DONE -> IDLE)
//   mem_read_*            read request channel (valid/address out, ready/data in)
//   mem_write_*           write request channel (valid/address/data out, ready in)
//   lsu_state             00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
//   lsu_out               last loaded value
//   error                 timeout flag
module thread_lsu #(
    parameter int ADDR_BITS      = 8,
    parameter int DATA_BITS      = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 start,
    input  logic                 op_read,
    input  logic                 op_write,
    input  logic [DATA_BITS-1:0] rs,
    input  logic [DATA_BITS-1:0] rt,
    input  logic                 ack,
    output logic                 mem_read_valid,
    output logic [ADDR_BITS-1:0] mem_read_address,
    input  logic                 mem_read_ready,
    input  logic [DATA_BITS-1:0] mem_read_data,
    output logic                 mem_write_valid,
    output logic [ADDR_BITS-1:0] mem_write_address,
    output logic [DATA_BITS-1:0] mem_write_data,
    input  logic                 mem_write_ready,
    output logic [1:0]           lsu_state,
    output logic [DATA_BITS-1:0] lsu_out,
    output logic                 error
);

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        REQUESTING = 2'b01,
        WAITING    = 2'b10,
        DONE       = 2'b11
    } state_t;

    state_t               state, next_state;
    logic                 accept;
    logic                 op_is_read;
    logic                 mem_ready;
    logic                 timeout;
    logic [ADDR_BITS-1:0] rs_addr;
    logic [ADDR_BITS-1:0] req_addr;
    logic [DATA_BITS-1:0] req_data;

    // Address is the low bits of rs, or rs zero-extended when the address is wider.
    generate
        if (ADDR_BITS <= DATA_BITS) begin : g_addr_trunc
            assign rs_addr = rs[ADDR_BITS-1:0];
        end else begin : g_addr_zext
            assign rs_addr = {{(ADDR_BITS-DATA_BITS){1'b0}}, rs};
        end
    endgenerate

    assign accept    = enable & start & (op_read | op_write);
    // Only the ready of the port carrying the latched op counts.
    assign mem_ready = op_is_read ? mem_read_ready : mem_write_ready;
    assign lsu_state = state;

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;

    // Fires on the last of TIMEOUT_CYCLES WAITING cycles; a ready on that same
    // edge takes precedence.
    assign timeout = (state == WAITING) && !mem_ready &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == REQUESTING) begin
            wait_cnt <= '0;
        end else if (state == WAITING) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            error <= 1'b0;
        end else if (state == IDLE && accept) begin
            error <= 1'b0;
        end else if (timeout) begin
            error <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    assign error   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (accept) next_state = REQUESTING;
            REQUESTING: next_state = WAITING;
            WAITING:    if (mem_ready || timeout) next_state = DONE;
            DONE:       if (ack) next_state = IDLE;
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            op_is_read        <= 1'b0;
            req_addr          <= '0;
            req_data          <= '0;
            mem_read_valid    <= 1'b0;
            mem_read_address  <= '0;
            mem_write_valid   <= 1'b0;
            mem_write_address <= '0;
            mem_write_data    <= '0;
            lsu_out           <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_is_read <= op_read;
                        req_addr   <= rs_addr;
                        req_data   <= rt;
                    end
                end
                REQUESTING: begin
                    if (op_is_read) begin
                        mem_read_valid   <= 1'b1;
                        mem_read_address <= req_addr;
                    end else begin
                        mem_write_valid   <= 1'b1;
                        mem_write_address <= req_addr;
                        mem_write_data    <= req_data;
                    end
                end
                WAITING: begin
                    if (mem_ready) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        if (op_is_read) lsu_out <= mem_read_data;
                    end else if (timeout) begin
                        mem_read_valid  <= 1'b0;
                        mem_write_valid <= 1'b0;
                        if (op_is_read) lsu_out <= '1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_thread_lsu.sv
module tb_thread_lsu;
    localparam int TO = 4;
`ifdef LSU_TIMEOUT_EN
    localparam int MAXD = TO - 1;
`else
    localparam int MAXD = 6;
`endif

    logic       clock = 1'b0;
    logic       reset, enable, start, op_read, op_write, ack;
    logic [7:0] rs, rt;
    logic       mem_read_valid, mem_read_ready;
    logic [7:0] mem_read_address, mem_read_data;
    logic       mem_write_valid, mem_write_ready;
    logic [7:0] mem_write_address, mem_write_data;
    logic [1:0] lsu_state;
    logic [7:0] lsu_out;
    logic       error;

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] mem [256];
    logic [7:0] exp_out;

    always #5 clock = ~clock;

    thread_lsu #(.ADDR_BITS(8), .DATA_BITS(8), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .enable(enable), .start(start),
        .op_read(op_read), .op_write(op_write), .rs(rs), .rt(rt), .ack(ack),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .lsu_state(lsu_state), .lsu_out(lsu_out), .error(error)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One complete transaction against the memory model; dly = idle valid
    // cycles before ready. Noise (start/ack/enable/other-port ready) is
    // applied while WAITING and must be ignored.
    task automatic run_txn(input bit rd, input bit wr, input logic [7:0] a,
                           input logic [7:0] d, input int dly);
        bit is_rd = rd;  // read wins when both are set
        check("txn_idle", lsu_state, 0);
        enable = 1; start = 1; op_read = rd; op_write = wr; rs = a; rt = d;
        step();
        start = 0; op_read = 1'($urandom); op_write = 1'($urandom);
        rs = 8'($urandom); rt = 8'($urandom);
        check("req_state", lsu_state, 1);
        check("req_valid", {mem_read_valid, mem_write_valid}, 0);
        step();
        check("wait_state", lsu_state, 2);
        check("rvalid", mem_read_valid, is_rd);
        check("wvalid", mem_write_valid, !is_rd);
        if (is_rd) check("raddr", mem_read_address, a);
        else begin
            check("waddr", mem_write_address, a);
            check("wdata", mem_write_data, d);
        end
        for (int k = 0; k < dly; k++) begin
            enable = 1'($urandom); start = 1'($urandom); ack = 1'($urandom);
            if (is_rd) mem_write_ready = 1'($urandom);
            else begin
                mem_read_ready = 1'($urandom);
                mem_read_data  = 8'($urandom);
            end
            step();
            check("wait_hold", lsu_state, 2);
            check("valid_hold", {mem_read_valid, mem_write_valid}, is_rd ? 2 : 1);
            check("addr_hold", is_rd ? mem_read_address : mem_write_address, a);
            check("err_wait", error, 0);
        end
        start = 0; ack = 0; mem_read_ready = 0; mem_write_ready = 0;
        if (is_rd) begin
            mem_read_ready = 1; mem_read_data = mem[a]; exp_out = mem[a];
        end else begin
            mem_write_ready = 1; mem[a] = d;
        end
        step();
        mem_read_ready = 0; mem_write_ready = 0; mem_read_data = 8'($urandom);
        check("done_state", lsu_state, 3);
        check("done_valid", {mem_read_valid, mem_write_valid}, 0);
        check("done_out", lsu_out, exp_out);
        check("done_err", error, 0);
        for (int k = 0; k < 2; k++) begin
            start = 1; enable = 1; op_read = 1;
            step();
            check("done_hold", lsu_state, 3);
        end
        start = 0; ack = 1;
        step();
        ack = 0;
        check("ack_idle", lsu_state, 0);
        check("ack_out", lsu_out, exp_out);
        check("ack_valid", {mem_read_valid, mem_write_valid}, 0);
    endtask

    initial begin
        reset = 1; enable = 0; start = 0; op_read = 0; op_write = 0; ack = 0;
        rs = 0; rt = 0; mem_read_ready = 0; mem_read_data = 0; mem_write_ready = 0;
        exp_out = 0;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        step(); step();
        check("rst_state", lsu_state, 0);
        check("rst_valid", {mem_read_valid, mem_write_valid}, 0);
        check("rst_addr", {mem_read_address, mem_write_address, mem_write_data}, 0);
        check("rst_out", lsu_out, 0);
        check("rst_err", error, 0);
        reset = 0;
        step();

        // Directed read with ready 3 cycles after valid.
        mem[8'h12] = 8'hA5;
        run_txn(1, 0, 8'h12, 8'h00, 3);
        check("t1_out", lsu_out, 8'hA5);
        // Directed write with ready in the first valid cycle.
        run_txn(0, 1, 8'h40, 8'h7E, 0);
        check("t2_out_kept", lsu_out, 8'hA5);

        // Ignored starts in IDLE: enable low, and no op selected.
        enable = 0; start = 1; op_read = 1;
        step();
        check("en0_state", lsu_state, 0);
        check("en0_valid", mem_read_valid, 0);
        enable = 1; op_read = 0; op_write = 0; ack = 1;
        step();
        check("noop_state", lsu_state, 0);
        start = 0; ack = 0;
        step();
        check("noop_valid", {mem_read_valid, mem_write_valid}, 0);

        // Both ops set: read wins.
        run_txn(1, 1, 8'h03, 8'h55, 1);

        // Reset while WAITING.
        enable = 1; start = 1; op_read = 1; op_write = 0; rs = 8'h33;
        step();
        start = 0;
        step();
        check("rw_valid", mem_read_valid, 1);
        reset = 1;
        step();
        reset = 0;
        check("rw_valid0", mem_read_valid, 0);
        check("rw_state", lsu_state, 0);
        check("rw_out", lsu_out, 0);
        exp_out = 0;
        step();

`ifdef LSU_TIMEOUT_EN
        begin
            int vcnt = 0;
            enable = 1; start = 1; op_read = 1; op_write = 0; rs = 8'h21;
            step();
            start = 0;
            step();
            for (int k = 0; k < TO + 3; k++) begin
                if (lsu_state != 2) break;
                if (mem_read_valid) vcnt++;
                step();
            end
            check("to_cycles", vcnt, TO);
            check("to_state", lsu_state, 3);
            check("to_valid", mem_read_valid, 0);
            check("to_err", error, 1);
            check("to_out", lsu_out, 8'hFF);
            exp_out = 8'hFF;
            ack = 1;
            step();
            ack = 0;
            check("to_err_held", error, 1);
            start = 1; op_read = 0; op_write = 1; rs = 8'h05; rt = 8'h66;
            step();
            start = 0;
            check("to_err_clr", error, 0);
            step();
            mem_write_ready = 1; mem[8'h05] = 8'h66;
            step();
            mem_write_ready = 0; ack = 1;
            step();
            ack = 0;
            check("to_after", lsu_state, 0);
        end
`endif

        // Random mix over a small address window so reads hit earlier writes.
        for (int t = 0; t < 40; t++) begin
            int sel = $urandom_range(0, 2);
            run_txn(sel != 1, sel != 0, 8'($urandom_range(0, 15)), 8'($urandom),
                    $urandom_range(0, MAXD));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
